// File: rtl/link_pkg.sv
// Shared link-layer types and CRC-32 constants used by the receive-side checkers.
package link_pkg;

   // OVERSIZE and ABORT share one code because the result field is only two bits wide
   typedef enum logic [1:0] {
      CAUSE_NONE              = 2'd0,
      CAUSE_CRC               = 2'd1,
      CAUSE_RUNT              = 2'd2,
      CAUSE_ABORT_OR_OVERSIZE = 2'd3
   } fail_cause_e;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of reflected CRC-32, LSB first, as a purely combinational step.
module crc32_byte_step
   import link_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  in_byte,
   output logic [31:0] crc_out
);

   logic [31:0] crc_work;

   always_comb begin
      crc_work = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0] ^ in_byte[i]) begin
            crc_work = (crc_work >> 1) ^ CRC32_POLY;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/frame_crc_checker.sv
// Frames a received byte stream on sof/eof, checks CRC-32 over data plus FCS and
// issues one registered result pulse per frame for link_monitor.
module frame_crc_checker
   import link_pkg::*;
#(
   parameter int MIN_BYTES = 5,
   parameter int MAX_BYTES = 1518,
   parameter int LEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic             frame_valid,
   output logic             crc_fail,
   output logic [1:0]       fail_cause,
   output logic [LEN_W-1:0] frame_len,
   output logic [7:0]       drop_cnt
);

   if (MAX_BYTES >= 2**LEN_W) begin : g_len_check
      $error("frame_crc_checker: MAX_BYTES does not fit in LEN_W bits");
   end

   typedef enum logic [1:0] {IDLE, IN_FRAME, DISCARD} state_e;

   localparam logic [LEN_W-1:0] MIN_LEN        = LEN_W'(MIN_BYTES);
   localparam logic [LEN_W-1:0] MAX_LEN        = LEN_W'(MAX_BYTES);
   localparam logic [LEN_W-1:0] ONE_LEN        = LEN_W'(1);
   localparam bit               SINGLE_IS_RUNT = (MIN_BYTES > 1);

   state_e           state_reg, state_next;
   logic [31:0]      crc_reg, crc_next, crc_seed, crc_step;
   logic [LEN_W-1:0] count_reg, count_next, count_inc;
   logic             frame_valid_reg;
   fail_cause_e      fail_cause_reg;
   logic [LEN_W-1:0] frame_len_reg;
   logic [7:0]       drop_cnt_reg;

   logic             rep_valid;
   fail_cause_e      rep_cause;
   logic [LEN_W-1:0] rep_len;
   logic             drop_inc;

   // A sof byte always folds into a freshly initialised register
   assign crc_seed  = in_sof ? CRC32_INIT : crc_reg;
   assign count_inc = (count_reg < MAX_LEN) ? count_reg + 1'b1 : count_reg;

   crc32_byte_step u_crc_step (
      .crc_in  (crc_seed),
      .in_byte (in_data),
      .crc_out (crc_step)
   );

   always_comb begin
      state_next = state_reg;
      crc_next   = crc_reg;
      count_next = count_reg;
      rep_valid  = 1'b0;
      rep_cause  = CAUSE_NONE;
      rep_len    = count_reg;
      drop_inc   = 1'b0;

      if (in_valid) begin
         unique case (state_reg)
            IDLE, DISCARD: begin
               if (in_sof) begin
                  crc_next   = crc_step;
                  count_next = ONE_LEN;
                  if (in_eof) begin
                     rep_valid  = 1'b1;
                     rep_len    = ONE_LEN;
                     state_next = IDLE;
                     if (SINGLE_IS_RUNT) begin
                        rep_cause = CAUSE_RUNT;
                     end else begin
                        rep_cause = (crc_step == CRC32_RESIDUE) ? CAUSE_NONE : CAUSE_CRC;
                     end
                  end else begin
                     state_next = IN_FRAME;
                  end
               end else if (in_eof && state_reg == DISCARD) begin
                  state_next = IDLE;
               end
            end

            IN_FRAME: begin
               if (in_sof) begin
                  // Old frame is reported as aborted; this byte opens the next one
                  rep_valid  = 1'b1;
                  rep_cause  = CAUSE_ABORT_OR_OVERSIZE;
                  rep_len    = count_reg;
                  crc_next   = crc_step;
                  count_next = ONE_LEN;
                  if (in_eof) begin
                     drop_inc   = 1'b1;
                     state_next = IDLE;
                  end
               end else begin
                  crc_next   = crc_step;
                  count_next = count_inc;
                  if (in_eof) begin
                     rep_valid  = 1'b1;
                     rep_len    = count_inc;
                     state_next = IDLE;
                     if (count_inc < MIN_LEN) begin
                        rep_cause = CAUSE_RUNT;
                     end else if (crc_step != CRC32_RESIDUE) begin
                        rep_cause = CAUSE_CRC;
                     end else begin
                        rep_cause = CAUSE_NONE;
                     end
                  end else if (count_inc == MAX_LEN) begin
                     rep_valid  = 1'b1;
                     rep_cause  = CAUSE_ABORT_OR_OVERSIZE;
                     rep_len    = MAX_LEN;
                     state_next = DISCARD;
                  end
               end
            end

            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         crc_reg         <= CRC32_INIT;
         count_reg       <= '0;
         frame_valid_reg <= 1'b0;
         fail_cause_reg  <= CAUSE_NONE;
         frame_len_reg   <= '0;
         drop_cnt_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         crc_reg         <= crc_next;
         count_reg       <= count_next;
         frame_valid_reg <= rep_valid;
         if (rep_valid) begin
            fail_cause_reg <= rep_cause;
            frame_len_reg  <= rep_len;
         end
         if (drop_inc && drop_cnt_reg != 8'hFF) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end
   end

   assign frame_valid = frame_valid_reg;
   assign fail_cause  = fail_cause_reg;
   assign crc_fail    = (fail_cause_reg != CAUSE_NONE);
   assign frame_len   = frame_len_reg;
   assign drop_cnt    = drop_cnt_reg;

endmodule
